md5_display_ctrl: RTL and testbench
===================================

Name: md5_display_ctrl

Overview:
- Top-level sequencer for the MD5 demo board.
- Conditions the raw board buttons, launches the MD5 core, and waits for completion with a timeout.
- Captures the finished digest and drives the digest viewer's control inputs: start, left_shift, right_shift and its synchronous rst.
- Sits between the board I/O and the MD5 core / digest-viewer pair.

Parameters:
HOLD_CYCLES, 16, cycles a shift button must be held continuously before auto-repeat begins
REPEAT_CYCLES, 4, period in cycles between auto-repeat shift pulses
TIMEOUT, 1024, maximum cycles spent in RUN waiting for md5_done before entering ERR

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
btn_run  input  1  raw run button, asynchronous to clk
btn_left  input  1  raw left-shift button, asynchronous
btn_right  input  1  raw right-shift button, asynchronous
btn_clear  input  1  raw clear button, asynchronous
md5_done  input  1  MD5 core completion strobe, synchronous, one cycle
md5_digest  input  128  MD5 core result, valid while md5_done=1
md5_go  output  1  one-cycle launch pulse to the MD5 core
digest_out  output  128  captured digest, feeds the viewer's data_in
start  output  1  viewer enable, high only in SHOW
left_shift  output  1  one-cycle shift pulse to the viewer
right_shift  output  1  one-cycle shift pulse to the viewer
disp_rst  output  1  one-cycle synchronous reset to the viewer's window offset
state  output  2  current state: 00 ENTRY, 01 RUN, 10 SHOW, 11 ERR
err  output  1  high while in ERR

Behaviour:
- Reset (async, any time, including mid-RUN): state=ENTRY; all outputs 0; digest_out=0; synchronizers, counters and edge registers cleared. No md5_go is issued after reset releases.
- Button conditioning, per button:
  - 2-flop synchronizer, then a previous-value flop.
  - Edge = sync2 & ~prev.
  - A raw rise first sampled at edge N produces an edge event in the cycle after edge N+2.
  - All pulses below are registered, so an output pulse appears one cycle after its edge event.
- ENTRY:
  - start=0; shift buttons are ignored.
  - Run edge -> RUN.
- RUN:
  - md5_go=1 in the first RUN cycle only.
  - Timeout counter starts at 0 on entry and increments every RUN cycle.
  - md5_done=1 -> digest_out<=md5_digest, then SHOW.
  - Counter reaches TIMEOUT-1 with no done -> ERR; digest_out is unchanged.
  - md5_done in the same cycle as the terminal count -> done wins.
  - Button edges are ignored, including run (no relaunch).
- SHOW:
  - start=1.
  - disp_rst=1 in the first SHOW cycle only; shift pulses are suppressed in that cycle.
  - Left edge -> left_shift pulse; right edge -> right_shift pulse.
  - Left and right edge events in the same cycle -> neither pulse.
  - Auto-repeat per direction: a counter runs while that button's sync2 stays high. First repeat pulse after HOLD_CYCLES held cycles, then every REPEAT_CYCLES. Release clears the counter. If both buttons are held, no repeats.
  - Clear edge -> ENTRY; digest_out is retained.
  - Run edge -> RUN (recompute); digest_out is held until the new done.
  - Clear has priority over run.
- ERR:
  - err=1, start=0.
  - Only a clear edge exits, to ENTRY.
- Pulse outputs (md5_go, left_shift, right_shift, disp_rst) are never high for 2 consecutive cycles, except left/right at REPEAT_CYCLES=1.
- Counter widths: $clog2 of the respective parameter, saturating; no wrap.

Test Plan:
- Normal run: reset, press btn_run for 5 cycles -> md5_go for 1 cycle, state=01. Drive md5_done with digest 128'h0123456789ABCDEFFEDCBA9876543210 -> digest_out equals it, disp_rst for 1 cycle, state=10, start=1.
- Shift edges (HOLD_CYCLES=16): in SHOW, press btn_left for 3 cycles -> exactly one left_shift pulse, 3 cycles after the raw rise; press btn_left and btn_right together -> no pulses.
- Auto-repeat: HOLD_CYCLES=8, REPEAT_CYCLES=4, hold btn_right for 30 cycles -> initial pulse, then pulses at held cycles 8, 12, 16, 20, 24, 28; none after release.
- Timeout: TIMEOUT=100, never assert md5_done -> state=11, err=1 at cycle 100 of RUN, digest_out unchanged. btn_clear -> state=00, err=0. A done at cycle 99 instead -> SHOW.
- Gating and priority:
  - btn_left in ENTRY and in RUN -> no left_shift.
  - btn_clear and btn_run pressed together in SHOW -> ENTRY, no md5_go.
- Async reset mid-RUN at cycle 40 -> all outputs 0 immediately, without waiting for a clk edge; state=00; no md5_go after release.

Source files
------------

// File: rtl/md5_display_ctrl.sv
// Board-level sequencer for the MD5 demo: conditions buttons, launches the core,
// guards completion with a timeout and drives the digest viewer's controls.
module md5_display_ctrl #(
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_run,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_clear,
  input  logic         md5_done,
  input  logic [127:0] md5_digest,
  output logic         md5_go,
  output logic [127:0] digest_out,
  output logic         start,
  output logic         left_shift,
  output logic         right_shift,
  output logic         disp_rst,
  output logic [1:0]   state,
  output logic         err
);

  localparam int HW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int TW = (TIMEOUT       > 1) ? $clog2(TIMEOUT)       : 1;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'b00,
    ST_RUN   = 2'b01,
    ST_SHOW  = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

  // Button bit order: 0 run, 1 left, 2 right, 3 clear.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] prev_q,  prev_d;
  logic [3:0] edge_q,  edge_d;

  assign btn_raw = {btn_clear, btn_right, btn_left, btn_run};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  logic run_e, left_e, right_e, clear_e;
  logic both_held;
  logic [1:0] rep_fire;

  assign run_e     = edge_q[0];
  assign left_e    = edge_q[1];
  assign right_e   = edge_q[2];
  assign clear_e   = edge_q[3];
  assign both_held = sync2_q[1] & sync2_q[2];

  // Auto-repeat per shift direction; the fire flop lines repeats up with edge_q.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_repeat
      logic [HW-1:0] hold_cnt_q, hold_cnt_d;
      logic [RW-1:0] rep_cnt_q,  rep_cnt_d;
      logic          fire_q,     fire_d;

      always_comb begin
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        fire_d     = 1'b0;
        if (sync2_q[gi+1]) begin
          if (hold_cnt_q != HW'(HOLD_CYCLES - 1)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q;
            fire_d     = (rep_cnt_q == '0) && !both_held;
            rep_cnt_d  = (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) ? '0 : rep_cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_cnt_q <= '0;
          rep_cnt_q  <= '0;
          fire_q     <= 1'b0;
        end else begin
          hold_cnt_q <= hold_cnt_d;
          rep_cnt_q  <= rep_cnt_d;
          fire_q     <= fire_d;
        end
      end

      assign rep_fire[gi] = fire_q;
    end
  endgenerate

  state_t         state_q, state_d;
  logic [127:0]   digest_q, digest_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           go_q, go_d;
  logic           left_q, left_d;
  logic           right_q, right_d;
  logic           disp_rst_q, disp_rst_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      digest_q   <= '0;
      tmo_q      <= '0;
      go_q       <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      disp_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digest_q   <= digest_d;
      tmo_q      <= tmo_d;
      go_q       <= go_d;
      left_q     <= left_d;
      right_q    <= right_d;
      disp_rst_q <= disp_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    digest_d   = digest_q;
    tmo_d      = '0;
    go_d       = 1'b0;
    left_d     = 1'b0;
    right_d    = 1'b0;
    disp_rst_d = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (run_e) begin
          state_d = ST_RUN;
          go_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (md5_done) begin
          digest_d   = md5_digest;
          state_d    = ST_SHOW;
          disp_rst_d = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end
      end
      ST_SHOW: begin
        if (clear_e) begin
          state_d = ST_ENTRY;
        end else if (run_e) begin
          state_d = ST_RUN;
          go_d    = 1'b1;
        end else if (!disp_rst_q) begin
          left_d  = ((left_e & ~right_e) | rep_fire[0]) && ((REPEAT_CYCLES == 1) || !left_q);
          right_d = ((right_e & ~left_e) | rep_fire[1]) && ((REPEAT_CYCLES == 1) || !right_q);
        end
      end
      ST_ERR: begin
        if (clear_e) begin
          state_d = ST_ENTRY;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
    // Count only while staying in RUN so every fresh entry starts from zero.
    if (state_q == ST_RUN && state_d == ST_RUN && tmo_q != TW'(TIMEOUT - 1)) begin
      tmo_d = tmo_q + 1'b1;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      tmo_d = tmo_q;
    end
  end

  always_comb begin
    state       = state_q;
    start       = (state_q == ST_SHOW);
    err         = (state_q == ST_ERR);
    md5_go      = go_q;
    left_shift  = left_q;
    right_shift = right_q;
    disp_rst    = disp_rst_q;
    digest_out  = digest_q;
  end

endmodule

// File: tb/tb_md5_display_ctrl.sv
// Bench for md5_display_ctrl: table of button/done vectors plus hand-written
// sequences; pulse outputs are checked against a cycle-stamped scoreboard.
module tb_md5_display_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_run = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_clear = 1'b0;
  logic         md5_done = 1'b0;
  logic [127:0] md5_digest = '0;
  logic         md5_go, start, left_shift, right_shift, disp_rst, err;
  logic [127:0] digest_out;
  logic [1:0]   state;

  md5_display_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst),
    .btn_run(btn_run), .btn_left(btn_left), .btn_right(btn_right), .btn_clear(btn_clear),
    .md5_done(md5_done), .md5_digest(md5_digest),
    .md5_go(md5_go), .digest_out(digest_out), .start(start),
    .left_shift(left_shift), .right_shift(right_shift), .disp_rst(disp_rst),
    .state(state), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] D2 = 128'hDEADBEEF00112233445566778899AABB;
  localparam logic [127:0] D3 = 128'hCAFEF00D0F1E2D3C4B5A69788796A5B4;

  // Expected cycle stamps per pulse output: 0 md5_go, 1 left, 2 right, 3 disp_rst.
  int q_go[$], q_left[$], q_right[$], q_drst[$];
  string pname[4] = '{"md5_go", "left_shift", "right_shift", "disp_rst"};

  task automatic push_pulse(input int kind, input int at);
    case (kind)
      0: q_go.push_back(at);
      1: q_left.push_back(at);
      2: q_right.push_back(at);
      default: q_drst.push_back(at);
    endcase
  endtask

  task automatic pop_pulse(input int kind);
    case (kind)
      0: void'(q_go.pop_front());
      1: void'(q_left.pop_front());
      2: void'(q_right.pop_front());
      default: void'(q_drst.pop_front());
    endcase
  endtask

  task automatic mon(input int kind, input logic v);
    bit have;
    int front;
    have  = 1'b0;
    front = 0;
    case (kind)
      0: if (q_go.size() > 0)    begin have = 1'b1; front = q_go[0];    end
      1: if (q_left.size() > 0)  begin have = 1'b1; front = q_left[0];  end
      2: if (q_right.size() > 0) begin have = 1'b1; front = q_right[0]; end
      default: if (q_drst.size() > 0) begin have = 1'b1; front = q_drst[0]; end
    endcase
    if (v) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL %s: unexpected pulse at cycle %0d, none required", pname[kind], cyc);
      end else begin
        if (front != cyc) begin
          errors++;
          $display("FAIL %s: pulse at cycle %0d, required at cycle %0d", pname[kind], cyc, front);
        end
        pop_pulse(kind);
      end
    end else if (have && front < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: no pulse seen, required at cycle %0d", pname[kind], front);
      pop_pulse(kind);
    end
  endtask

  always @(negedge clk) begin
    mon(0, md5_go);
    mon(1, left_shift);
    mon(2, right_shift);
    mon(3, disp_rst);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic btn_drive(input logic [3:0] m, output int k);
    @(posedge clk); #1;
    k = cyc;
    {btn_clear, btn_right, btn_left, btn_run} = m;
  endtask

  task automatic hold_release(input int dur);
    repeat (dur) @(posedge clk);
    #1;
    {btn_clear, btn_right, btn_left, btn_run} = 4'b0000;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // act: 0 run, 1 left, 2 right, 3 clear, 4 done, 5 run+clear, 6 left+right
  typedef struct {
    int           act;
    int           dur;
    logic [127:0] din;
    logic [1:0]   st;
    logic         sta;
    logic         er;
    logic [127:0] dig;
  } vec_t;

  vec_t        vecs[13];
  logic [1:0]  prev_st;
  logic [3:0]  mask;
  int          k;
  int          kd;

  initial begin
    vecs[0]  = '{0, 5, '0, 2'b01, 1'b0, 1'b0, '0};
    vecs[1]  = '{1, 3, '0, 2'b01, 1'b0, 1'b0, '0};
    vecs[2]  = '{4, 1, D1, 2'b10, 1'b1, 1'b0, D1};
    vecs[3]  = '{1, 3, '0, 2'b10, 1'b1, 1'b0, D1};
    vecs[4]  = '{2, 3, '0, 2'b10, 1'b1, 1'b0, D1};
    vecs[5]  = '{6, 3, '0, 2'b10, 1'b1, 1'b0, D1};
    vecs[6]  = '{5, 3, '0, 2'b00, 1'b0, 1'b0, D1};
    vecs[7]  = '{1, 3, '0, 2'b00, 1'b0, 1'b0, D1};
    vecs[8]  = '{0, 3, '0, 2'b01, 1'b0, 1'b0, D1};
    vecs[9]  = '{4, 1, D2, 2'b10, 1'b1, 1'b0, D2};
    vecs[10] = '{0, 3, '0, 2'b01, 1'b0, 1'b0, D2};
    vecs[11] = '{4, 1, D1, 2'b10, 1'b1, 1'b0, D1};
    vecs[12] = '{3, 3, '0, 2'b00, 1'b0, 1'b0, D1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset state", 128'(state), 128'(2'b00));
    chk("reset start", 128'(start), 128'(1'b0));
    chk("reset err", 128'(err), 128'(1'b0));
    chk("reset digest_out", digest_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    prev_st = 2'b00;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].act == 4) begin
        @(posedge clk); #1;
        k = cyc;
        md5_done   = 1'b1;
        md5_digest = vecs[i].din;
        if (prev_st == 2'b01) push_pulse(3, k + 1);
        @(posedge clk); #1;
        md5_done   = 1'b0;
        md5_digest = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        case (vecs[i].act)
          0: mask = 4'b0001;
          1: mask = 4'b0010;
          2: mask = 4'b0100;
          3: mask = 4'b1000;
          5: mask = 4'b1001;
          default: mask = 4'b0110;
        endcase
        btn_drive(mask, k);
        if (vecs[i].act == 0 && (prev_st == 2'b00 || prev_st == 2'b10)) push_pulse(0, k + 4);
        if (vecs[i].act == 1 && prev_st == 2'b10) push_pulse(1, k + 4);
        if (vecs[i].act == 2 && prev_st == 2'b10) push_pulse(2, k + 4);
        hold_release(vecs[i].dur);
      end
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d state", i), 128'(state), 128'(vecs[i].st));
      chk($sformatf("vec%0d start", i), 128'(start), 128'(vecs[i].sta));
      chk($sformatf("vec%0d err", i), 128'(err), 128'(vecs[i].er));
      chk($sformatf("vec%0d digest_out", i), digest_out, vecs[i].dig);
      $display("vec%0d act=%0d state=%b start=%b err=%b digest=%h", i, vecs[i].act, state, start, err, digest_out);
      prev_st = vecs[i].st;
    end

    // Timeout: RUN cycle 0 is cyc k+4, terminal count in RUN cycle 99, ERR in cycle 100.
    btn_drive(4'b0001, k);
    push_pulse(0, k + 4);
    hold_release(3);
    wait_until(k + 103);
    @(negedge clk);
    chk("timeout run cycle 99 state", 128'(state), 128'(2'b01));
    @(posedge clk);
    @(negedge clk);
    chk("timeout state", 128'(state), 128'(2'b11));
    chk("timeout err", 128'(err), 128'(1'b1));
    chk("timeout start", 128'(start), 128'(1'b0));
    chk("timeout digest_out", digest_out, D1);
    $display("timeout: state=%b err=%b digest=%h", state, err, digest_out);
    btn_drive(4'b1000, k);
    hold_release(3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("err clear state", 128'(state), 128'(2'b00));
    chk("err clear err", 128'(err), 128'(1'b0));

    // Done arriving on the terminal-count cycle wins over timeout.
    btn_drive(4'b0001, k);
    push_pulse(0, k + 4);
    hold_release(3);
    wait_until(k + 103);
    kd = cyc;
    md5_done   = 1'b1;
    md5_digest = D3;
    push_pulse(3, kd + 1);
    @(posedge clk); #1;
    md5_done   = 1'b0;
    md5_digest = '0;
    @(negedge clk);
    chk("late done state", 128'(state), 128'(2'b10));
    chk("late done digest_out", digest_out, D3);
    $display("late done: state=%b digest=%h", state, digest_out);

    // Auto-repeat on right: edge pulse, then held cycles 8, 12, ... 28.
    repeat (4) @(posedge clk);
    btn_drive(4'b0100, k);
    push_pulse(2, k + 4);
    for (int h = 8; h <= 28; h += 4) push_pulse(2, k + 3 + h);
    hold_release(30);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("repeat pending right", 128'(q_right.size()), 128'(0));
    $display("auto-repeat right done at cycle %0d", cyc);

    // Both shift buttons held: neither edge pulses nor repeats.
    btn_drive(4'b0110, k);
    hold_release(20);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("both held state", 128'(state), 128'(2'b10));
    $display("both held: state=%b", state);

    // Asynchronous reset in RUN cycle 40.
    btn_drive(4'b0001, k);
    push_pulse(0, k + 4);
    hold_release(3);
    wait_until(k + 44);
    chk("pre-reset state", 128'(state), 128'(2'b01));
    #1;
    rst = 1'b1;
    #1;
    chk("async reset state", 128'(state), 128'(2'b00));
    chk("async reset digest_out", digest_out, '0);
    chk("async reset pulses", 128'({md5_go, left_shift, right_shift, disp_rst, start, err}), 128'(0));
    $display("async reset: state=%b digest=%h", state, digest_out);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("post-reset state", 128'(state), 128'(2'b00));

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending pulses", 128'(q_go.size() + q_left.size() + q_right.size() + q_drst.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
